fifo_flags: RTL
===============

Name: fifo_flags

Overview:
- Parametrised synchronous ring-buffer FIFO for any depth, including non-power-of-2 depths.
- Adds an occupancy count, almost-full/almost-empty flags, empty-bypass and explicit full/empty handling.
- Used as the general-purpose buffer between producer/consumer stages on the single system clock.
- Keeps the existing rd_en/rd_val/wr_en/wr_ready handshake naming.

Parameters:
- FIFO_DEPTH, 100, number of storage entries (>=2, any integer).
- DATA_WIDTH, 8, width of wr_data/rd_data.
- AFULL_LVL, FIFO_DEPTH-1, almost_full asserts when count >= AFULL_LVL (1..FIFO_DEPTH).
- AEMPTY_LVL, 1, almost_empty asserts when count <= AEMPTY_LVL (0..FIFO_DEPTH-1).
- CNT_W, $clog2(FIFO_DEPTH+1), width of count (derived; do not override).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- wr_ready  out  1  FIFO can accept a write this cycle.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  read data, registered.
- rd_val  out  1  rd_data valid, one-cycle pulse per accepted read.
- count  out  CNT_W  current occupancy, 0..FIFO_DEPTH.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AEMPTY_LVL.
- almost_full  out  1  count >= AFULL_LVL.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - head, tail, count = 0.
  - rd_data = 0, rd_val = 0.
  - wr_ready = 1, empty = 1, almost_empty = 1, almost_full = 0 (unless AFULL_LVL = 0, which is illegal).
  - Memory contents are not reset.
- Status outputs are decoded combinationally from the count register only, so they change one cycle after the event that causes them:
  - wr_ready = (count < FIFO_DEPTH).
  - empty, almost_empty, almost_full as defined under Ports.
- Write acceptance: wr_acc = wr_en & wr_ready.
  - An accepted write stores wr_data at mem[tail], and tail advances.
  - wr_en while full is dropped silently; no state changes.
- Read acceptance: rd_acc = rd_en & ~empty.
  - An accepted read registers mem[head] into rd_data, and head advances.
  - rd_val = 1 on the next cycle.
  - Latency is 1 cycle from rd_en to rd_val.
- Pointer wrap: a pointer equal to FIFO_DEPTH-1 advances to 0. Pointer width is $clog2(FIFO_DEPTH).
- Count update:
  - +1 for wr_acc only.
  - -1 for rd_acc only.
  - Unchanged when both or neither occur.
- Empty bypass: when empty & rd_en & wr_en in the same cycle:
  - rd_data <= wr_data and rd_val <= 1 next cycle.
  - Memory, pointers and count are unchanged.
- rd_en while empty with no wr_en: rd_val <= 0 next cycle, rd_data holds its previous value.
- Full with rd_en & wr_en: the read is accepted, the write is dropped (wr_ready was 0), count becomes FIFO_DEPTH-1.
- Non-full, non-empty, rd_en & wr_en: both are accepted, count is unchanged, and the read returns the oldest entry.
- rd_val is 0 in every cycle not following an accepted read or bypass.
- Reset asserted mid-operation discards all contents; the next cycle behaves as post-reset.

Optional Feature:
- Macro: FIFO_FLAGS_ERR_EN.
- When defined, add two ports and a clear input:
  - ovf_err  out  1: sticky, set the cycle after wr_en while full.
  - udf_err  out  1: sticky, set the cycle after rd_en while empty without bypass.
  - err_clr  in  1: clears both flags next cycle; a new set in the same cycle wins over clear.
  - Both flags reset to 0.
- When not defined, these ports and their logic do not exist. Data-path behaviour is identical in both builds.

Test Plan:
- Reset, then 5 writes 0x11..0x15 with FIFO_DEPTH=5 -> count=5, wr_ready=0, almost_full=1 (AFULL_LVL=4) from the cycle after the 4th write.
- Full FIFO, 6th write of 0xAA, then 5 reads -> rd_data sequence 0x11..0x15 each 1 cycle after rd_en, rd_val pulses 5 times, 0xAA never appears; with FIFO_FLAGS_ERR_EN, ovf_err=1.
- Empty FIFO, rd_en & wr_en with 0x5C in one cycle -> next cycle rd_val=1, rd_data=0x5C, count stays 0, empty stays 1.
- FIFO_DEPTH=5, 20 interleaved writes/reads of an incrementing pattern keeping count at 2..3 -> pointers wrap past 4 to 0, output order is exactly the write order, no rd_val on empty reads.
- Full FIFO, rd_en & wr_en simultaneously -> read returns the oldest entry, write is dropped, count=4, wr_ready=1 next cycle.
- Reset asserted with count=3 mid-stream -> next cycle count=0, empty=1, rd_val=0, rd_data=0; a subsequent rd_en gives rd_val=0 (and udf_err=1 when FIFO_FLAGS_ERR_EN is defined).

Source files
------------

// File: rtl/fifo_flags.sv
// fifo_flags: synchronous ring-buffer FIFO for any depth (power of 2 or not)
// with occupancy count, almost-full/almost-empty flags, empty bypass and
// explicit full/empty handling. Single clock, synchronous active-high reset.
//
// Status outputs (wr_ready, empty, almost_empty, almost_full) are decoded
// from the count register only, so they follow an event by one cycle.
//
// Optional feature, enabled by defining FIFO_FLAGS_ERR_EN:
//   sticky overflow/underflow error flags (ovf_err, udf_err) with a clear
//   input (err_clr). A new error in the same cycle as err_clr wins.
// The data path is identical with or without the macro.
//
// Parameter legality: FIFO_DEPTH >= 2, 1 <= AFULL_LVL <= FIFO_DEPTH,
// 0 <= AEMPTY_LVL <= FIFO_DEPTH-1. CNT_W is derived and must not be
// overridden.

module fifo_flags #(
  parameter int FIFO_DEPTH = 100,
  parameter int DATA_WIDTH = 8,
  parameter int AFULL_LVL  = FIFO_DEPTH - 1,
  parameter int AEMPTY_LVL = 1,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_val,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  almost_full
`ifdef FIFO_FLAGS_ERR_EN
  ,
  input  logic                  err_clr,
  output logic                  ovf_err,
  output logic                  udf_err
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  // Storage and pointers. head = oldest entry, tail = next free slot.
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      head_nxt;
  logic [PTR_W-1:0]      tail_nxt;

  // Handshake qualifiers.
  logic bypass;   // empty FIFO, simultaneous read and write: pass data through
  logic wr_acc;   // write stored into memory
  logic rd_acc;   // read served from memory

  // Status flags decoded purely from the count register.
  assign wr_ready     = (count < DEPTH_C);
  assign empty        = (count == '0);
  assign almost_empty = (count <= AEMPTY_C);
  assign almost_full  = (count >= AFULL_C);

  // The bypass consumes the write directly, so it never touches memory.
  assign bypass = empty & rd_en & wr_en;
  assign wr_acc = wr_en & wr_ready & ~bypass;
  assign rd_acc = rd_en & ~empty;

  // Next-pointer computation with explicit wrap for non-power-of-2 depths.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    head_nxt = head;
    tail_nxt = tail;
    if (rd_acc) begin
      head_nxt = (head == LAST_PTR) ? '0 : head + PTR_W'(1);
    end
    if (wr_acc) begin
      tail_nxt = (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
    end
  end

  // Occupancy counter: +1 on write only, -1 on read only.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (wr_acc && !rd_acc) begin
      count <= count + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count <= count - CNT_W'(1);
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; contents are only ever read
    // after being written, and a reset here would block RAM inference.
    if (wr_acc) begin
      mem[tail] <= wr_data;
    end
  end

  // Registered read port: memory read, empty bypass, or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
      rd_val  <= 1'b0;
    end else begin
      rd_val <= rd_acc | bypass;
      if (rd_acc) begin
        rd_data <= mem[head];
      end else if (bypass) begin
        rd_data <= wr_data;
      end
    end
  end

`ifdef FIFO_FLAGS_ERR_EN
  logic ovf_set;
  logic udf_set;

  // Overflow: write attempted while full. Underflow: read while empty and
  // not rescued by the bypass.
  assign ovf_set = wr_en & ~wr_ready;
  assign udf_set = rd_en & empty & ~wr_en;

  // Sticky error flags; a new set in the clearing cycle takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_set | (ovf_err & ~err_clr);
      udf_err <= udf_set | (udf_err & ~err_clr);
    end
  end
`endif

endmodule
